// File: rtl/sim_halt_monitor.sv
// Simulation run controller: holds the core under test in reset, watches decode
// for a halt encoding or a cycle timeout, drains the pipeline, then reports done/pass.
module sim_halt_monitor #(
  parameter int unsigned       XLEN         = 32,
  parameter logic [XLEN-1:0]   HALT_INSN    = XLEN'(32'h0000_2013),
  parameter logic [XLEN-1:0]   HALT_MASK    = {XLEN{1'b1}},
  parameter int unsigned       RESET_CYCLES = 2,
  parameter int unsigned       DRAIN_CYCLES = 5,
  parameter int unsigned       TIMEOUT      = 100000,
  parameter int unsigned       CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             insn_valid,
  input  logic [XLEN-1:0]  insn,
  output logic             core_reset_n,
  output logic             done,
  output logic             pass,
  output logic             timed_out,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] insn_count,
  output logic [XLEN-1:0]  last_insn
);

  localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned DRN_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 32'd1);
  localparam logic [DRN_W-1:0]  DRN_LOAD  = DRN_W'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT - 32'd1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic              TO_EN     = (TIMEOUT != 32'd0);
  localparam logic              NO_DRAIN  = (DRAIN_CYCLES == 32'd0);
  localparam logic [XLEN-1:0]   HALT_CMP  = HALT_INSN & HALT_MASK;

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [HOLD_W-1:0] hold_cnt_q,   hold_cnt_d;
  logic [DRN_W-1:0]  drain_cnt_q,  drain_cnt_d;
  logic [CNT_W-1:0]  cycle_cnt_q,  cycle_cnt_d;
  logic [CNT_W-1:0]  insn_cnt_q,   insn_cnt_d;
  logic [XLEN-1:0]   last_insn_q,  last_insn_d;
  logic              to_hit_q,     to_hit_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic              done_q,       done_d;
  logic              timed_out_q,  timed_out_d;
  logic              pass_q,       pass_d;

  logic in_run_s;
  logic halt_match_s;
  logic timeout_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  assign in_run_s     = (state_q == S_RUN);
  assign halt_match_s = in_run_s & insn_valid & ((insn & HALT_MASK) == HALT_CMP);
  assign timeout_s    = in_run_s & TO_EN & (cycle_cnt_q == TO_LAST);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a halt match takes priority over a coincident timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = S_RUN;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_RUN: begin
        if (halt_match_s) begin
          state_d = NO_DRAIN ? S_DONE : S_DRAIN;
        end else if (timeout_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DRN_W'(1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_HOLD;
      end
    endcase
  end

  // Counter and flag next values; done/timed_out follow the DONE state by one edge
  always_comb begin
    hold_cnt_d   = hold_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    cycle_cnt_d  = cycle_cnt_q;
    insn_cnt_d   = insn_cnt_q;
    last_insn_d  = last_insn_q;
    to_hit_d     = to_hit_q;
    core_rst_n_d = (state_d != S_HOLD);

    if (state_q == S_HOLD && hold_cnt_q != HOLD_LAST) begin
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    end else begin
      hold_cnt_d = hold_cnt_q;
    end

    if (halt_match_s) begin
      drain_cnt_d = DRN_LOAD;
    end else if (state_q == S_DRAIN) begin
      drain_cnt_d = drain_cnt_q - DRN_W'(1);
    end else begin
      drain_cnt_d = drain_cnt_q;
    end

    if (state_q == S_RUN || state_q == S_DRAIN) begin
      cycle_cnt_d = sat_inc(cycle_cnt_q);
    end else begin
      cycle_cnt_d = cycle_cnt_q;
    end

    if (in_run_s && insn_valid) begin
      insn_cnt_d  = sat_inc(insn_cnt_q);
      last_insn_d = insn;
    end else begin
      insn_cnt_d  = insn_cnt_q;
      last_insn_d = last_insn_q;
    end

    if (timeout_s && !halt_match_s) begin
      to_hit_d = 1'b1;
    end else begin
      to_hit_d = to_hit_q;
    end

    done_d      = done_q | (state_q == S_DONE);
    timed_out_d = timed_out_q | ((state_q == S_DONE) & to_hit_q);
    pass_d      = done_d & ~timed_out_d;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt_q   <= '0;
      drain_cnt_q  <= '0;
      cycle_cnt_q  <= '0;
      insn_cnt_q   <= '0;
      last_insn_q  <= '0;
      to_hit_q     <= 1'b0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      timed_out_q  <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
      insn_cnt_q   <= insn_cnt_d;
      last_insn_q  <= last_insn_d;
      to_hit_q     <= to_hit_d;
      core_rst_n_q <= core_rst_n_d;
      done_q       <= done_d;
      timed_out_q  <= timed_out_d;
      pass_q       <= pass_d;
    end
  end

  assign core_reset_n = core_rst_n_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign timed_out    = timed_out_q;
  assign cycle_count  = cycle_cnt_q;
  assign insn_count   = insn_cnt_q;
  assign last_insn    = last_insn_q;

endmodule

// File: doc/sim_halt_monitor.md
SIM_HALT_MONITOR -- requirements
Module: sim_halt_monitor

Interface
REQ-001 Parameter XLEN, default 32: instruction width in bits.
REQ-002 Parameter HALT_INSN, default 32'h00002013 (slti x0,x0,0): halt encoding.
REQ-003 Parameter HALT_MASK, default all ones: bits of insn compared against HALT_INSN.
REQ-004 Parameter RESET_CYCLES, default 2, legal range >= 1: cycles core_reset_n is held low after reset_n release.
REQ-005 Parameter DRAIN_CYCLES, default 5, legal range >= 0: cycles between halt match and done.
REQ-006 Parameter TIMEOUT, default 100000: RUN-cycle limit; 0 disables the timeout.
REQ-007 Parameter CNT_W, default 32: width of the cycle and instruction counters.
REQ-008 clk  input  1  single clock; all state updates on the rising edge.
REQ-009 reset_n  input  1  asynchronous, active-low reset.
REQ-010 insn_valid  input  1  insn carries a decoded instruction this cycle.
REQ-011 insn  input  XLEN  decode-stage instruction word.
REQ-012 core_reset_n  output  1  registered active-low reset to the core under test.
REQ-013 done  output  1  sticky end-of-run flag.
REQ-014 pass  output  1  done and not timed_out.
REQ-015 timed_out  output  1  sticky timeout flag.
REQ-016 cycle_count  output  CNT_W  cycles spent in RUN and DRAIN.
REQ-017 insn_count  output  CNT_W  valid instructions accepted in RUN.
REQ-018 last_insn  output  XLEN  most recent valid insn captured in RUN.

Function
REQ-019 FSM states: HOLD, RUN, DRAIN, DONE.
REQ-020 HOLD: hold counter increments each edge; transition to RUN on the edge where it equals RESET_CYCLES-1; core_reset_n is low in HOLD and high in RUN, DRAIN and DONE.
REQ-021 Result: core_reset_n rises exactly RESET_CYCLES rising edges after the first edge sampled with reset_n high.
REQ-022 Halt match: insn_valid=1 and (insn & HALT_MASK) == (HALT_INSN & HALT_MASK), evaluated in RUN only.
REQ-023 RUN on match: go to DRAIN with drain counter loaded to DRAIN_CYCLES; if DRAIN_CYCLES=0, go directly to DONE.
REQ-024 DRAIN: drain counter decrements each edge; go to DONE on the edge where it equals 1; done therefore rises DRAIN_CYCLES+1 edges after the match cycle's edge (1 edge when DRAIN_CYCLES=0).
REQ-025 Timeout: in RUN with TIMEOUT != 0 and cycle_count == TIMEOUT-1 and no match this cycle -> DONE with timed_out=1.
REQ-026 Simultaneous halt match and timeout condition: the halt match wins; timed_out stays 0.
REQ-027 cycle_count increments on every edge in RUN and DRAIN and freezes in HOLD and DONE.
REQ-028 insn_count increments, and last_insn loads insn, on each RUN edge with insn_valid=1; the halt instruction itself is counted and captured.
REQ-029 insn_valid and insn are ignored in HOLD, DRAIN and DONE.
REQ-030 Both counters saturate at all ones and never wrap.
REQ-031 DONE is absorbing until reset_n is asserted; done and timed_out are sticky; pass = done & ~timed_out, registered or derived combinationally from registered state.
REQ-032 A second halt match in DRAIN neither restarts nor extends the drain.

Reset
REQ-033 While reset_n=0, asynchronously: state=HOLD, all counters=0, core_reset_n=0, done=0, pass=0, timed_out=0, cycle_count=0, insn_count=0, last_insn=0.
REQ-034 reset_n asserted in any state, including mid-DRAIN or DONE, aborts the run immediately; after release, the full HOLD sequence repeats.
REQ-035 Synchronous deassertion of reset_n is the environment's responsibility; no internal synchronizer is required.

Verification
REQ-036 Defaults; reset_n released before edge E0 -> core_reset_n=0 at E0, 1 after E1; cycle_count=0 until after E2.
REQ-037 Defaults; 3 valid non-halt insns, then 32'h00002013 valid -> insn_count=4, last_insn=32'h00002013; done=1 and pass=1 exactly 6 edges after the match edge; cycle_count frozen thereafter.
REQ-038 TIMEOUT=10, never match -> done=1, timed_out=1, pass=0, cycle_count=10 after the 10th RUN edge.
REQ-039 TIMEOUT=10, halt match on the 10th RUN cycle -> DRAIN entered, timed_out=0, pass=1 at the end.
REQ-040 DRAIN_CYCLES=0, HALT_MASK=32'h0000707F, insn 32'hFFF02013 valid -> masked match; done=1 on the next edge.
REQ-041 reset_n pulsed low mid-DRAIN -> all outputs 0 immediately; after release, HOLD repeats and the counters restart from 0.
